// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks active-low columns, debounces press and release,
// and reports one strobe per accepted key with held-level and multi-row flags.
module keypad_scanner #(
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int CODE_W          = 4,
   parameter int SCAN_DIV        = 16,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ROWS-1:0]   row_in,
   output logic [COLS-1:0]   col_out,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_down,
   output logic              multi_key
);
   // state      | meaning
   // SCAN       | rotate columns, sample rows at end of each dwell
   // PRESS_DB   | column frozen, waiting for row_pat to stay stable
   // HELD       | key accepted, waiting for all rows to go high
   // RELEASE_DB | waiting for all rows to stay high

   localparam int CIW = $clog2(COLS);
   localparam int RIW = $clog2(ROWS);
   localparam int DWW = $clog2(SCAN_DIV);
   localparam int DBW = $clog2(DEBOUNCE_CYCLES);
   localparam int LCW = $clog2(ROWS + 1);
   localparam logic [DWW-1:0] DW_LAST  = DWW'(SCAN_DIV - 1);
   localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CIW-1:0] COL_LAST = CIW'(COLS - 1);

   typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;
   state_t state, state_nxt;

   logic [ROWS-1:0] rs_meta, rs, row_pat;
   logic [DWW-1:0]  dwell;
   logic [DBW-1:0]  db_cnt;
   logic [CIW-1:0]  col_idx;
   logic [RIW-1:0]  row_idx, first_low;
   logic [LCW-1:0]  low_cnt;
   logic            rows_idle, rs_match, dwell_done, db_done;
   logic            accept, advance_col, capture;

   assign rows_idle  = (rs == '1);
   assign rs_match   = (rs == row_pat);
   assign dwell_done = (dwell == DW_LAST);
   assign db_done    = (db_cnt == DB_LAST);

   always_comb begin
      first_low = '0;
      for (int i = ROWS - 1; i >= 0; i--)
         if (!rs[i]) first_low = RIW'(i);
   end

   always_comb begin
      low_cnt = '0;
      for (int i = 0; i < ROWS; i++)
         if (!row_pat[i]) low_cnt = low_cnt + LCW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= SCAN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SCAN:       if (dwell_done && !rows_idle) state_nxt = PRESS_DB;
         PRESS_DB:   if (!rs_match) state_nxt = SCAN;
                     else if (db_done) state_nxt = HELD;
         HELD:       if (rows_idle) state_nxt = RELEASE_DB;
         RELEASE_DB: if (!rows_idle) state_nxt = HELD;
                     else if (db_done) state_nxt = SCAN;
         default:    state_nxt = SCAN;
      endcase
   end

   assign accept      = (state == PRESS_DB) && rs_match && db_done;
   assign capture     = (state == SCAN) && dwell_done && !rows_idle;
   assign advance_col = ((state == SCAN) && dwell_done && rows_idle) ||
                        ((state == PRESS_DB) && !rs_match) ||
                        ((state == RELEASE_DB) && rows_idle && db_done);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs_meta   <= '1;
         rs        <= '1;
         dwell     <= '0;
         db_cnt    <= '0;
         col_idx   <= '0;
         row_pat   <= '1;
         row_idx   <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         multi_key <= 1'b0;
      end else begin
         rs_meta   <= row_in;
         rs        <= rs_meta;
         dwell     <= ((state == SCAN) && !dwell_done) ? dwell + DWW'(1) : '0;
         // counter restarts on every state change, so it never wraps
         if (state_nxt != state)
            db_cnt <= '0;
         else if ((state == PRESS_DB) || (state == RELEASE_DB))
            db_cnt <= db_cnt + DBW'(1);
         else
            db_cnt <= '0;
         if (advance_col)
            col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + CIW'(1);
         if (capture) begin
            row_pat <= rs;
            row_idx <= first_low;
         end
         key_valid <= accept;
         if (accept) begin
            key_code  <= CODE_W'(col_idx) * CODE_W'(ROWS) + CODE_W'(row_idx);
            multi_key <= (low_cnt > LCW'(1));
         end
      end
   end

   always_comb begin
      col_out  = ~(COLS'(1) << col_idx);
      key_down = (state == HELD) || (state == RELEASE_DB);
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simple key-matrix model drives rows from col_out;
// expected strobes are queued by stimulus and checked by a separate monitor.
module tb_keypad_scanner;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid, key_down, multi_key;
   logic [15:0] keys;

   typedef struct packed {logic [3:0] code; logic multi;} exp_t;
   exp_t sb[$];

   int n_tests = 0;
   int n_fail  = 0;
   logic prev_kv = 1'b0;

   keypad_scanner #(.ROWS(4), .COLS(4), .CODE_W(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
      .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .multi_key(multi_key)
   );

   always #5 clk = ~clk;

   // key index = col*4 + row; a pressed key pulls its row low while its column is driven
   always_comb begin
      row_in = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] exp_col(input int idx);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << idx);
   endfunction

   always @(negedge clk) begin
      if (key_valid) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe: got code %0d expected no strobe", key_code);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("strobe_code", 32'(key_code), 32'(e.code));
            check("strobe_multi", 32'(multi_key), 32'(e.multi));
         end
         if (prev_kv) check("strobe_single_cycle", 32'(prev_kv), 32'd0);
      end
      prev_kv = key_valid;
   end

   task automatic wait_pulse(input string name, input int max, output int lat);
      lat = 0;
      while (lat < max) begin
         @(negedge clk);
         lat++;
         if (key_valid) break;
      end
      check(name, 32'(key_valid), 32'd1);
   endtask

   task automatic wait_release(input string name, input int max, output int n);
      n = 0;
      while (n < max && key_down) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(key_down), 32'd0);
   endtask

   initial begin
      int lat, n;
      keys  = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_col_out", 32'(col_out), 32'hE);
      check("rst_key_code", 32'(key_code), 32'd0);
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_key_down", 32'(key_down), 32'd0);
      check("rst_multi_key", 32'(multi_key), 32'd0);
      reset = 1'b0;

      // idle scan: each column for 4 clocks, wrapping
      for (int k = 0; k < 32; k++) begin
         check("idle_col_seq", 32'(col_out), 32'(exp_col((k / 4) % 4)));
         @(negedge clk);
      end
      repeat (68) @(negedge clk);
      check("idle_key_code", 32'(key_code), 32'd0);
      check("idle_key_down", 32'(key_down), 32'd0);

      // single key col2 row1 -> code 9
      keys[9] = 1'b1;
      sb.push_back('{code: 4'd9, multi: 1'b0});
      wait_pulse("press9_pulse", 40, lat);
      check("press9_latency_range", 32'(lat >= 10 && lat <= 30), 32'd1);
      check("press9_key_down", 32'(key_down), 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("press9_col_frozen", 32'(col_out), 32'hB);
      end
      check("press9_held", 32'(key_down), 32'd1);

      // release with a 5-clock glitch back to pressed
      keys[9] = 1'b0;
      repeat (4) @(negedge clk);
      check("glitch_pre_key_down", 32'(key_down), 32'd1);
      keys[9] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("glitch_key_down", 32'(key_down), 32'd1);
      end
      keys[9] = 1'b0;
      wait_release("release9_fall", 30, n);
      check("release9_min_delay", 32'(n >= 9 && n <= 12), 32'd1);
      check("release9_next_col", 32'(col_out), 32'h7);
      check("release9_code_kept", 32'(key_code), 32'd9);

      // bouncing press on col1 row3 -> code 7
      for (int i = 0; i < 20; i++) begin
         if (i % 3 == 0) keys[7] = ~keys[7];
         @(negedge clk);
      end
      keys[7] = 1'b1;
      sb.push_back('{code: 4'd7, multi: 1'b0});
      wait_pulse("bounce7_pulse", 40, lat);
      check("bounce7_key_down", 32'(key_down), 32'd1);
      keys[7] = 1'b0;
      wait_release("bounce7_release", 30, n);

      // two rows on col1: lowest row wins, multi flagged
      keys[4] = 1'b1;
      keys[6] = 1'b1;
      sb.push_back('{code: 4'd4, multi: 1'b1});
      wait_pulse("multi_pulse", 40, lat);
      check("multi_key_down", 32'(key_down), 32'd1);
      keys = '0;
      wait_release("multi_release", 30, n);

      // reset in the middle of press debounce (col3 row2)
      keys[14] = 1'b1;
      n = 0;
      while (n < 40 && !(dut.state == 2'd1 && dut.db_cnt == 3'd5)) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_db5", 32'(dut.db_cnt == 3'd5), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("abort_col_out", 32'(col_out), 32'hE);
      check("abort_key_code", 32'(key_code), 32'd0);
      check("abort_key_valid", 32'(key_valid), 32'd0);
      check("abort_key_down", 32'(key_down), 32'd0);
      check("abort_multi_key", 32'(multi_key), 32'd0);
      keys = '0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("abort_rescan", 32'(col_out), 32'(exp_col(k / 4)));
         @(negedge clk);
      end
      repeat (40) @(negedge clk);
      check("abort_no_strobe_code", 32'(key_code), 32'd0);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
